fetch_ctrl: RTL and testbench

Sequencing controller for the front-end program counter. Owns the PC write port and the fetch/issue enables, with fixed priority trap > branch mispredict. Owns the instruction-mapping window registers: a mapping miss stalls fetch, a refill handshake with the memory controller runs, and fetch resumes at the missing PC. Sits between the ROB/branch unit, the program counter block and the memory controller.

---
 rtl/fetch_ctrl_pkg.sv | 34 +++
 rtl/fetch_ctrl_redirect_arb.sv | 36 +++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end types and constants for the fetch sequencing controller.
package fetch_ctrl_pkg;

   // Controller phases: boot load, normal fetch, refill request, refill wait, resume load.
   typedef enum logic [2:0] {
      StBoot,
      StRun,
      StReq,
      StWait,
      StResume
   } FetchCtrlState;

   // log2 of the mapping window size in bytes.
   localparam int unsigned MAP_WIN_BITS_FULL = 14;
   localparam int unsigned MAP_WIN_BITS_HALF = 13;

   typedef struct packed {
      logic        valid;
      logic        isTrap;
      logic [31:0] pc;
   } redirect_t;

   // Align an address down to the start of its mapping window.
   function automatic logic [31:0] win_base(input logic [31:0] addr, input logic half);
      logic [31:0] mask;
      if (half) begin
         mask = ~((32'd1 << MAP_WIN_BITS_HALF) - 32'd1);
      end else begin
         mask = ~((32'd1 << MAP_WIN_BITS_FULL) - 32'd1);
      end
      return addr & mask;
   endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Trap/mispredict priority merge and the pending-redirect update rule.
module fetch_ctrl_redirect_arb
   import fetch_ctrl_pkg::*;
(
   input  logic        i_trapValid,
   input  logic [31:0] i_trapPC,
   input  logic        i_misprValid,
   input  logic [31:0] i_misprPC,
   input  redirect_t   i_pending,
   output redirect_t   o_redirect,
   output redirect_t   o_pendingNext
);

   // Current-cycle redirect: trap always beats mispredict.
   always_comb begin
      o_redirect = '0;
      if (i_trapValid) begin
         o_redirect.valid  = 1'b1;
         o_redirect.isTrap = 1'b1;
         o_redirect.pc     = i_trapPC;
      end else if (i_misprValid) begin
         o_redirect.valid  = 1'b1;
         o_redirect.isTrap = 1'b0;
         o_redirect.pc     = i_misprPC;
      end
   end

   // Pending update: a trap replaces anything, a mispredict never displaces a held trap.
   always_comb begin
      o_pendingNext = i_pending;
      if (o_redirect.valid && (o_redirect.isTrap || !(i_pending.valid && i_pending.isTrap))) begin
         o_pendingNext = o_redirect;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: PC redirects, mapping-window refill and fetch enables.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0,
   parameter logic [31:0] RESET_MAP_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IN_trapValid,
   input  logic [31:0] IN_trapPC,
   input  logic        IN_misprValid,
   input  logic [31:0] IN_misprPC,
   input  logic        IN_stall,
   input  logic [31:0] IN_pcRaw,
   input  logic        IN_mappingMiss,
   input  logic        IN_halfSize,
   output logic        OUT_en0,
   output logic        OUT_en1,
   output logic        OUT_pcWrite,
   output logic [31:0] OUT_pc,
   output logic        OUT_flush,
   output logic [31:0] OUT_mappingBase,
   output logic        OUT_memReq,
   output logic [31:0] OUT_memAddr,
   input  logic        IN_memAck,
   input  logic        IN_memDone,
   output logic [15:0] OUT_refillCount
);

   localparam logic [31:0] PC_MASK      = 32'hFFFF_FFFE;
   localparam logic [31:0] MAP_BASE_RST =
      RESET_MAP_BASE & ~((32'd1 << MAP_WIN_BITS_FULL) - 32'd1);

   FetchCtrlState r_state, w_state_next;
   logic          r_pc_write, w_pc_write_next;
   logic          r_flush, w_flush_next;
   logic [31:0]   r_pc, w_pc_next;
   logic          r_mem_req, w_mem_req_next;
   logic [31:0]   r_mem_addr, w_mem_addr_next;
   logic [31:0]   r_map_base, w_map_base_next;
   logic [15:0]   r_refill_cnt, w_refill_cnt_next;
   logic [31:0]   r_miss_pc, w_miss_pc_next;
   redirect_t     r_pending, w_pending_next;
   redirect_t     w_redirect;
   redirect_t     w_pend_merged;

   fetch_ctrl_redirect_arb u_redirect_arb (
      .i_trapValid   (IN_trapValid),
      .i_trapPC      (IN_trapPC),
      .i_misprValid  (IN_misprValid),
      .i_misprPC     (IN_misprPC),
      .i_pending     (r_pending),
      .o_redirect    (w_redirect),
      .o_pendingNext (w_pend_merged)
   );

   // State and registered outputs; reset drops any refill in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StBoot;
         r_pc_write   <= 1'b0;
         r_flush      <= 1'b0;
         r_pc         <= 32'h0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_map_base   <= MAP_BASE_RST;
         r_refill_cnt <= 16'h0;
         r_miss_pc    <= 32'h0;
         r_pending    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pc_write   <= w_pc_write_next;
         r_flush      <= w_flush_next;
         r_pc         <= w_pc_next;
         r_mem_req    <= w_mem_req_next;
         r_mem_addr   <= w_mem_addr_next;
         r_map_base   <= w_map_base_next;
         r_refill_cnt <= w_refill_cnt_next;
         r_miss_pc    <= w_miss_pc_next;
         r_pending    <= w_pending_next;
      end
   end

   // Next-state logic; pcWrite and flush are single-cycle pulses by default.
   always_comb begin
      w_state_next      = r_state;
      w_pc_write_next   = 1'b0;
      w_flush_next      = 1'b0;
      w_pc_next         = r_pc;
      w_mem_req_next    = r_mem_req;
      w_mem_addr_next   = r_mem_addr;
      w_map_base_next   = r_map_base;
      w_refill_cnt_next = r_refill_cnt;
      w_miss_pc_next    = r_miss_pc;
      w_pending_next    = r_pending;
      unique case (r_state)
         StBoot: begin
            w_pc_write_next = 1'b1;
            w_pc_next       = RESET_PC & PC_MASK;
            w_state_next    = StRun;
         end
         StRun: begin
            // A redirect outranks a miss: the miss belongs to a PC being discarded.
            if (w_redirect.valid) begin
               w_pc_write_next = 1'b1;
               w_flush_next    = 1'b1;
               w_pc_next       = w_redirect.pc & PC_MASK;
            end else if (IN_mappingMiss) begin
               w_miss_pc_next  = IN_pcRaw;
               w_mem_addr_next = win_base(IN_pcRaw, IN_halfSize);
               w_mem_req_next  = 1'b1;
               w_state_next    = StReq;
            end
         end
         StReq: begin
            w_pending_next = w_pend_merged;
            if (IN_memAck) begin
               w_mem_req_next = 1'b0;
               w_state_next   = StWait;
            end
         end
         StWait: begin
            w_pending_next = w_pend_merged;
            if (IN_memDone) begin
               w_map_base_next = r_mem_addr;
               if (r_refill_cnt != 16'hFFFF) begin
                  w_refill_cnt_next = r_refill_cnt + 16'd1;
               end
               w_state_next = StResume;
            end
         end
         StResume: begin
            // A redirect arriving this very cycle is folded in so it is not lost.
            w_pc_write_next = 1'b1;
            w_flush_next    = w_pend_merged.valid;
            w_pc_next       = (w_pend_merged.valid ? w_pend_merged.pc : r_miss_pc) & PC_MASK;
            w_pending_next  = '0;
            w_state_next    = StRun;
         end
         default: begin
            w_state_next = StBoot;
         end
      endcase
   end

   assign OUT_en0         = (r_state == StRun) & ~IN_stall & ~IN_mappingMiss & ~r_pc_write;
   assign OUT_en1         = ~IN_stall;
   assign OUT_pcWrite     = r_pc_write;
   assign OUT_pc          = r_pc;
   assign OUT_flush       = r_flush;
   assign OUT_mappingBase = r_map_base;
   assign OUT_memReq      = r_mem_req;
   assign OUT_memAddr     = r_mem_addr;
   assign OUT_refillCount = r_refill_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, hand sequences, randomized model run.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC   = 32'h0000_0100;
   localparam logic [31:0] RST_MAP  = 32'h0003_FFFF;
   localparam logic [31:0] EXP_BASE = 32'h0003_C000;

   logic        clk;
   logic        rst;
   logic        trapValid, misprValid, stall, mappingMiss, halfSize, memAck, memDone;
   logic [31:0] trapPC, misprPC, pcRaw;
   logic        en0, en1, pcWrite, flush, memReq;
   logic [31:0] pc, mappingBase, memAddr;
   logic [15:0] refillCount;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(
      .RESET_PC       (RST_PC),
      .RESET_MAP_BASE (RST_MAP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .IN_trapValid    (trapValid),
      .IN_trapPC       (trapPC),
      .IN_misprValid   (misprValid),
      .IN_misprPC      (misprPC),
      .IN_stall        (stall),
      .IN_pcRaw        (pcRaw),
      .IN_mappingMiss  (mappingMiss),
      .IN_halfSize     (halfSize),
      .OUT_en0         (en0),
      .OUT_en1         (en1),
      .OUT_pcWrite     (pcWrite),
      .OUT_pc          (pc),
      .OUT_flush       (flush),
      .OUT_mappingBase (mappingBase),
      .OUT_memReq      (memReq),
      .OUT_memAddr     (memAddr),
      .IN_memAck       (memAck),
      .IN_memDone      (memDone),
      .OUT_refillCount (refillCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        tv;
      logic [31:0] tpc;
      logic        mv;
      logic [31:0] mpc;
      logic        st;
      logic        miss;
      logic [31:0] raw;
      logic        ack;
      logic        done;
      logic        x_en0;
      logic        x_en1;
      logic        x_pcw;
      logic [31:0] x_pc;
      logic        x_fl;
      logic        x_req;
      logic [31:0] x_addr;
      logic [31:0] x_base;
      logic [15:0] x_cnt;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic tv, input logic [31:0] tpc, input logic mv,
                               input logic [31:0] mpc, input logic st, input logic miss,
                               input logic [31:0] raw, input logic ack, input logic done,
                               input logic x_en0, input logic x_en1, input logic x_pcw,
                               input logic [31:0] x_pc, input logic x_fl, input logic x_req,
                               input logic [31:0] x_addr, input logic [31:0] x_base,
                               input logic [15:0] x_cnt);
      vec_t v;
      v.tv = tv; v.tpc = tpc; v.mv = mv; v.mpc = mpc; v.st = st; v.miss = miss;
      v.raw = raw; v.ack = ack; v.done = done;
      v.x_en0 = x_en0; v.x_en1 = x_en1; v.x_pcw = x_pcw; v.x_pc = x_pc; v.x_fl = x_fl;
      v.x_req = x_req; v.x_addr = x_addr; v.x_base = x_base; v.x_cnt = x_cnt;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int idx, input logic x_en0,
                            input logic x_en1, input logic x_pcw, input logic [31:0] x_pc,
                            input logic x_fl, input logic x_req, input logic [31:0] x_addr,
                            input logic [31:0] x_base, input logic [15:0] x_cnt);
      check({tag, ".en0"}, idx, 32'(en0), 32'(x_en0));
      check({tag, ".en1"}, idx, 32'(en1), 32'(x_en1));
      check({tag, ".pcWrite"}, idx, 32'(pcWrite), 32'(x_pcw));
      check({tag, ".pc"}, idx, pc, x_pc);
      check({tag, ".flush"}, idx, 32'(flush), 32'(x_fl));
      check({tag, ".memReq"}, idx, 32'(memReq), 32'(x_req));
      check({tag, ".memAddr"}, idx, memAddr, x_addr);
      check({tag, ".mapBase"}, idx, mappingBase, x_base);
      check({tag, ".refillCnt"}, idx, 32'(refillCount), 32'(x_cnt));
   endtask

   task automatic drive(input logic tv, input logic [31:0] tpc, input logic mv,
                        input logic [31:0] mpc, input logic st, input logic miss,
                        input logic [31:0] raw, input logic ack, input logic done);
      trapValid = tv; trapPC = tpc; misprValid = mv; misprPC = mpc; stall = st;
      mappingMiss = miss; pcRaw = raw; memAck = ack; memDone = done;
   endtask

   task automatic idle();
      drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
   endtask

   // Behavioural reference: which refill milestone is outstanding, plus expected outputs.
   logic        m_boot, m_await_ack, m_await_done, m_resume_due;
   logic        m_pend_v, m_pend_trap;
   logic [31:0] m_pend_pc, m_miss_pc;
   logic        e_pcw, e_fl;
   logic [31:0] e_pc, e_addr, e_base;
   logic [15:0] e_cnt;

   task automatic model_reset();
      m_boot = 1; m_await_ack = 0; m_await_done = 0; m_resume_due = 0;
      m_pend_v = 0; m_pend_trap = 0; m_pend_pc = 0; m_miss_pc = 0;
      e_pcw = 0; e_fl = 0; e_pc = 0; e_addr = 0; e_base = EXP_BASE; e_cnt = 0;
   endtask

   function automatic logic model_en0();
      logic fetching;
      fetching = !(m_boot || m_await_ack || m_await_done || m_resume_due);
      return fetching && !stall && !mappingMiss && !e_pcw;
   endfunction

   // Advance the reference across one rising edge using the inputs currently applied.
   task automatic model_edge();
      logic [31:0] win;
      e_pcw = 0;
      e_fl  = 0;
      if (m_boot) begin
         m_boot = 0;
         e_pcw  = 1;
         e_pc   = RST_PC;
      end else if (m_await_ack || m_await_done || m_resume_due) begin
         if (trapValid) begin
            m_pend_v = 1; m_pend_trap = 1; m_pend_pc = trapPC;
         end else if (misprValid && !(m_pend_v && m_pend_trap)) begin
            m_pend_v = 1; m_pend_trap = 0; m_pend_pc = misprPC;
         end
         if (m_resume_due) begin
            e_pcw = 1;
            e_fl  = m_pend_v;
            e_pc  = (m_pend_v ? m_pend_pc : m_miss_pc) & 32'hFFFF_FFFE;
            m_pend_v = 0; m_pend_trap = 0; m_resume_due = 0;
         end else if (m_await_ack) begin
            if (memAck) begin
               m_await_ack = 0; m_await_done = 1;
            end
         end else if (memDone) begin
            e_base = e_addr;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            m_await_done = 0; m_resume_due = 1;
         end
      end else begin
         if (trapValid || misprValid) begin
            e_pcw = 1;
            e_fl  = 1;
            e_pc  = (trapValid ? trapPC : misprPC) & 32'hFFFF_FFFE;
         end else if (mappingMiss) begin
            win = halfSize ? 32'd8192 : 32'd16384;
            m_miss_pc   = pcRaw;
            e_addr      = pcRaw - (pcRaw % win);
            m_await_ack = 1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b;
      b = EXP_BASE;
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 1, 0, 32'h0, 0, 0, 32'h0, b, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 1, 1, 32'h100, 0, 0, 32'h0, b, 0);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 32'h100, 0, 0, 32'h0, b, 0);
      vecs[3]  = mk(1, 32'h80, 1, 32'h2000, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0, 0, 32'h0, b, 0);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 1, 1, 32'h80, 1, 0, 32'h0, b, 0);
      vecs[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0,             0, 0, 0, 32'h80, 0, 0, 32'h0, b, 0);
      vecs[6]  = mk(0, 0, 0, 0, 0, 1, 32'h0001_4010, 0, 0, 0, 1, 0, 32'h80, 0, 0, 32'h0, b, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 32'h80, 0, 1, 32'h14000, b, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,         0, 1, 0, 32'h80, 0, 1, 32'h14000, b, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0,         0, 1, 0, 32'h80, 0, 1, 32'h14000, b, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0,         0, 1, 0, 32'h80, 0, 0, 32'h14000, b, 0);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,         0, 1, 0, 32'h80, 0, 0, 32'h14000, b, 0);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 1, 0, 32'h80, 0, 0, 32'h14000, 32'h14000, 1);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 1, 1, 32'h0001_4010, 0, 0, 32'h14000, 32'h14000, 1);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 1, 0, 32'h0001_4010, 0, 0, 32'h14000, 32'h14000, 1);

      // Reset state, then the boot/redirect/refill table.
      rst = 1'b0;
      halfSize = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, EXP_BASE, 16'h0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rst = 1'b1;
         drive(vecs[i].tv, vecs[i].tpc, vecs[i].mv, vecs[i].mpc, vecs[i].st, vecs[i].miss,
               vecs[i].raw, vecs[i].ack, vecs[i].done);
         #1;
         check_all("table", i, vecs[i].x_en0, vecs[i].x_en1, vecs[i].x_pcw, vecs[i].x_pc,
                   vecs[i].x_fl, vecs[i].x_req, vecs[i].x_addr, vecs[i].x_base, vecs[i].x_cnt);
      end

      // Slow ack: request and address must hold steady until accepted.
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 32'h0002_7FFE, 0, 0);
      #1;
      check_all("slow", 0, 0, 1, 0, 32'h0001_4010, 0, 0, 32'h14000, 32'h14000, 1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         idle();
         memAck = (i == 6);
         #1;
         check_all("slow", i, 0, 1, 0, 32'h0001_4010, 0, 1, 32'h24000, 32'h14000, 1);
      end
      // Mispredict while waiting for the refill wins over the miss PC at resume.
      @(negedge clk);
      drive(0, 0, 1, 32'h40, 0, 0, 0, 0, 0);
      #1;
      check_all("wmis", 0, 0, 1, 0, 32'h0001_4010, 0, 0, 32'h24000, 32'h14000, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      check_all("wmis", 1, 0, 1, 0, 32'h0001_4010, 0, 0, 32'h24000, 32'h14000, 1);
      @(negedge clk);
      idle();
      #1;
      check_all("wmis", 2, 0, 1, 0, 32'h0001_4010, 0, 0, 32'h24000, 32'h24000, 2);
      @(negedge clk);
      #1;
      check_all("wmis", 3, 0, 1, 1, 32'h40, 1, 0, 32'h24000, 32'h24000, 2);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
      #1;
      check_all("wmis", 4, 0, 1, 0, 32'h40, 0, 0, 32'h24000, 32'h24000, 2);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      check_all("win0", 0, 0, 1, 0, 32'h40, 0, 1, 32'h0, 32'h24000, 2);
      @(negedge clk);
      idle();
      #1;
      check_all("win0", 1, 0, 1, 0, 32'h40, 0, 0, 32'h0, 32'h24000, 2);

      // Asynchronous reset while waiting for the refill, then a fresh boot.
      #1;
      rst = 1'b0;
      #1;
      check_all("areset", 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, EXP_BASE, 0);
      @(negedge clk);
      #1;
      check_all("areset", 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, EXP_BASE, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all("reboot", 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, EXP_BASE, 0);
      @(negedge clk);
      #1;
      check_all("reboot", 1, 0, 1, 1, 32'h100, 0, 0, 32'h0, EXP_BASE, 0);
      @(negedge clk);
      #1;
      check_all("reboot", 2, 1, 1, 0, 32'h100, 0, 0, 32'h0, EXP_BASE, 0);

      // Randomized traffic against the reference, once per window size.
      for (int seg = 0; seg < 2; seg++) begin
         @(negedge clk);
         rst = 1'b0;
         idle();
         halfSize = (seg == 1);
         model_reset();
         for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst         = 1'b1;
            trapValid   = ($urandom_range(11) == 0);
            trapPC      = $urandom;
            misprValid  = ($urandom_range(7) == 0);
            misprPC     = $urandom;
            stall       = ($urandom_range(3) == 0);
            mappingMiss = ($urandom_range(3) == 0);
            pcRaw       = $urandom;
            memAck      = ($urandom_range(2) == 0);
            memDone     = ($urandom_range(2) == 0);
            #1;
            check_all(seg == 0 ? "rnd16k" : "rnd8k", c, model_en0(), !stall, e_pcw, e_pc, e_fl,
                      m_await_ack, e_addr, e_base, e_cnt);
            model_edge();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
